// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32I load/store data memory responder with wait states
// Optional macro DMEM_RESPONDER_ERR_EN reports misaligned/undefined accesses instead of coercing them.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_mem_rw,
  input  logic [2:0]  i_req_load_store_mode,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt;
  logic [AW+1:0] addr_q;
  logic          rw_q;
  logic [2:0]    mode_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept, access, undef, err;
  logic [2:0]    mode_e;
  logic [AW+1:0] addr_e;
  logic [31:0]   word, load_data, wword;
  logic [3:0]    wmask;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^i_req_addr[31:AW+2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_req_valid) state_nx = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nx = S_RESP;
      S_RESP:  if (i_rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (state == S_IDLE);
    o_rsp_valid = (state == S_RESP);
  end

  assign accept = (state == S_IDLE) && i_req_valid;
  // The access fires once the wait counter has fully drained, one edge after it reaches zero.
  assign access = (state == S_WAIT) && (cnt == 4'd0);
  assign undef  = rw_q ? (mode_q > 3'b010) : ((mode_q == 3'b011) || (mode_q[2:1] == 2'b11));

`ifdef DMEM_RESPONDER_ERR_EN
  assign mode_e = mode_q;
  assign addr_e = addr_q;
  assign err    = undef
                || ((mode_q[1:0] == 2'b01) && addr_q[0])
                || ((mode_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign mode_e = undef ? 3'b010 : mode_q;
  assign err    = 1'b0;
  always_comb begin
    addr_e = addr_q;
    if (mode_e[1:0] == 2'b01) addr_e[0] = 1'b0;
    if (mode_e[1:0] == 2'b10) addr_e[1:0] = 2'b00;
  end
`endif

  assign word = mem[addr_e[AW+1:2]];

  always_comb begin
    case (addr_e[1:0])
      2'b00:   sel_byte = word[7:0];
      2'b01:   sel_byte = word[15:8];
      2'b10:   sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = addr_e[1] ? word[31:16] : word[15:0];
    case (mode_e[1:0])
      2'b00:   load_data = {{24{sel_byte[7] & ~mode_e[2]}}, sel_byte};
      2'b01:   load_data = {{16{sel_half[15] & ~mode_e[2]}}, sel_half};
      default: load_data = word;
    endcase
  end

  always_comb begin
    case (mode_e[1:0])
      2'b00: begin
        wmask = 4'b0001 << addr_e[1:0];
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wmask = addr_e[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wword = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (access && rw_q && !err) begin
      for (int b = 0; b < 4; b++)
        if (wmask[b]) mem[addr_e[AW+1:2]][8*b +: 8] <= wword[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      mode_q  <= 3'b000;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= WAIT_CYCLES[3:0];
        addr_q  <= i_req_addr[AW+1:0];
        rw_q    <= i_req_mem_rw;
        mode_q  <= i_req_load_store_mode;
        wdata_q <= i_req_wdata;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rdata_q <= (rw_q || err) ? 32'd0 : load_data;
        err_q   <= err;
      end else if (state == S_RESP && i_rsp_ready) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end
    end
  end

  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
endmodule
